// File: rtl/bpu_update_ctrl.sv
// Branch resolution controller: detects mispredicts, drives flush/redirect, and
// serialises resolved branches onto the single BPU update port through a small FIFO.
module bpu_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [63:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [63:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [63:0]      ex_pred_target,
    input  logic             upd_hold,
    output logic             ex_stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic             branch_resolved,
    output logic             actual_taken,
    output logic [63:0]      branch_pc,
    output logic [63:0]      branch_target_resolved,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_reg;
    logic [FW-1:0]     flush_cnt_reg;
    logic              flush_reg;
    logic              redirect_valid_reg;
    logic [63:0]       redirect_pc_reg;

    logic [63:0]       pc_mem    [DEPTH];
    logic              taken_mem [DEPTH];
    logic [63:0]       tgt_mem   [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    logic              branch_resolved_reg;
    logic              actual_taken_reg;
    logic [63:0]       branch_pc_reg;
    logic [63:0]       branch_target_reg;
    logic [CNT_W-1:0]  br_count_reg;
    logic [CNT_W-1:0]  mp_count_reg;

    logic              accepted;
    logic              mispredict;
    logic              full;
    logic              push;
    logic              pop;
    logic [63:0]       correct_pc;

    always_comb begin
        accepted   = ex_valid & (state_reg == IDLE);
        mispredict = accepted & ((ex_taken != ex_pred_taken) |
                                 (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
        full       = (count_reg == CW'(DEPTH));
        push       = accepted & ~full;
        pop        = ~upd_hold & (count_reg != '0);
        correct_pc = ex_taken ? ex_target : ex_pc + 64'd4;
    end

    // Flush FSM: the down-counter holds the remaining FLUSH cycles after the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            flush_cnt_reg      <= '0;
            flush_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            redirect_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mispredict) begin
                        state_reg          <= FLUSH;
                        flush_cnt_reg      <= FW'(FLUSH_CYCLES - 1);
                        flush_reg          <= 1'b1;
                        redirect_valid_reg <= 1'b1;
                        redirect_pc_reg    <= correct_pc;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        flush_reg <= 1'b0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - FW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Storage has no reset so it can map onto plain RAM; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= ex_pc;
            taken_mem[wr_ptr_reg] <= ex_taken;
            tgt_mem[wr_ptr_reg]   <= ex_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            count_reg           <= '0;
            branch_resolved_reg <= 1'b0;
            actual_taken_reg    <= 1'b0;
            branch_pc_reg       <= '0;
            branch_target_reg   <= '0;
        end else begin
            branch_resolved_reg <= pop;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg        <= rd_ptr_reg + AW'(1);
                actual_taken_reg  <= taken_mem[rd_ptr_reg];
                branch_pc_reg     <= pc_mem[rd_ptr_reg];
                branch_target_reg <= tgt_mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_reg <= '0;
            mp_count_reg <= '0;
        end else begin
            if (accepted && (br_count_reg != '1)) begin
                br_count_reg <= br_count_reg + CNT_W'(1);
            end
            if (mispredict && (mp_count_reg != '1)) begin
                mp_count_reg <= mp_count_reg + CNT_W'(1);
            end
        end
    end

    assign ex_stall               = full;
    assign flush                  = flush_reg;
    assign redirect_valid         = redirect_valid_reg;
    assign redirect_pc            = redirect_pc_reg;
    assign branch_resolved        = branch_resolved_reg;
    assign actual_taken           = actual_taken_reg;
    assign branch_pc              = branch_pc_reg;
    assign branch_target_resolved = branch_target_reg;
    assign br_count               = br_count_reg;
    assign mp_count               = mp_count_reg;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Self-checking bench for bpu_update_ctrl: directed table, hand sequences for
// stall/saturation/reset, and randomized traffic against a queue-based model.
module tb_bpu_update_ctrl;
    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic        ex_taken;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic        upd_hold;

    logic        ex_stall, flush, redirect_valid, branch_resolved, actual_taken;
    logic [63:0] redirect_pc, branch_pc, branch_target_resolved;
    logic [31:0] br_count, mp_count;

    logic        s_ex_stall, s_flush, s_redirect_valid, s_branch_resolved, s_actual_taken;
    logic [63:0] s_redirect_pc, s_branch_pc, s_branch_target_resolved;
    logic [2:0]  s_br_count, s_mp_count;

    always #5 clk = ~clk;

    bpu_update_ctrl dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .upd_hold(upd_hold), .ex_stall(ex_stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_resolved(branch_resolved), .actual_taken(actual_taken),
        .branch_pc(branch_pc), .branch_target_resolved(branch_target_resolved),
        .br_count(br_count), .mp_count(mp_count)
    );

    bpu_update_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .upd_hold(upd_hold), .ex_stall(s_ex_stall), .flush(s_flush), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .branch_resolved(s_branch_resolved), .actual_taken(s_actual_taken),
        .branch_pc(s_branch_pc), .branch_target_resolved(s_branch_target_resolved),
        .br_count(s_br_count), .mp_count(s_mp_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending updates, remaining flush cycles, plain counters.
    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] tgt;
    } ent_t;

    ent_t            m_q[$];
    int              m_fl;
    bit              m_rv;
    logic [63:0]     m_rpc;
    bit              m_br;
    bit              m_act;
    logic [63:0]     m_bpc;
    logic [63:0]     m_btgt;
    longint unsigned m_brc, m_mpc;
    int              m_brs, m_mps;

    task automatic model_reset();
        m_q.delete();
        m_fl = 0; m_rv = 0; m_rpc = '0; m_br = 0; m_act = 0; m_bpc = '0; m_btgt = '0;
        m_brc = 0; m_mpc = 0; m_brs = 0; m_mps = 0;
    endtask

    task automatic model_edge();
        bit   acc, mis, was_full;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        acc      = ex_valid && (m_fl == 0);
        mis      = acc && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
        was_full = (m_q.size() == DEPTH);
        m_br = 0;
        if (!upd_hold && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_br = 1; m_act = e.taken; m_bpc = e.pc; m_btgt = e.tgt;
        end
        if (acc && !was_full) begin
            e.pc = ex_pc; e.taken = ex_taken; e.tgt = ex_target;
            m_q.push_back(e);
        end
        if (acc) begin
            if (m_brc < 64'hFFFF_FFFF) m_brc++;
            if (m_brs < 7) m_brs++;
        end
        m_rv = 0;
        if (mis) begin
            if (m_mpc < 64'hFFFF_FFFF) m_mpc++;
            if (m_mps < 7) m_mps++;
            m_fl  = FLUSH_CYCLES;
            m_rv  = 1;
            m_rpc = ex_taken ? ex_target : ex_pc + 64'd4;
        end else if (m_fl > 0) begin
            m_fl--;
        end
    endtask

    task automatic step();
        chk("ex_stall_pre", ex_stall, m_q.size() == DEPTH);
        model_edge();
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b v=%0b pc=%h hold=%0b -> flush=%0b rv=%0b rpc=%h br=%0b bpc=%h brc=%0d mpc=%0d",
                 $time, reset, ex_valid, ex_pc, upd_hold, flush, redirect_valid, redirect_pc,
                 branch_resolved, branch_pc, br_count, mp_count);
        chk("flush", flush, m_fl > 0);
        chk("redirect_valid", redirect_valid, m_rv);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("branch_resolved", branch_resolved, m_br);
        chk("actual_taken", actual_taken, m_act);
        chk("branch_pc", branch_pc, m_bpc);
        chk("branch_target", branch_target_resolved, m_btgt);
        chk("br_count", br_count, m_brc);
        chk("mp_count", mp_count, m_mpc);
        chk("s_br_count", s_br_count, m_brs);
        chk("s_mp_count", s_mp_count, m_mps);
        chk("s_ctrl", {s_ex_stall, s_flush, s_redirect_valid, s_branch_resolved, s_actual_taken},
            {m_q.size() == DEPTH, m_fl > 0, m_rv, m_br, m_act});
        chk("s_branch_pc", s_branch_pc, m_bpc);
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input bit t, input logic [63:0] tgt,
                         input bit pt, input logic [63:0] ptg, input bit hold);
        ex_valid = v; ex_pc = pc; ex_taken = t; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptg; upd_hold = hold;
    endtask

    typedef struct {
        bit          v;
        logic [63:0] pc;
        bit          t;
        logic [63:0] tgt;
        bit          pt;
        logic [63:0] ptg;
        bit          e_flush;
        bit          e_rv;
        logic [63:0] e_rpc;
        bit          e_br;
        logic [63:0] e_bpc;
        int          e_brc;
        int          e_mpc;
    } vec_t;

    vec_t vt[9];

    initial begin
        // correct prediction, direction mispredict with ignored branch in flush, target mispredict
        vt[0] = '{1, 64'h100, 1, 64'h200, 1, 64'h200, 0, 0, 64'h0,   0, 64'h0,   1, 0};
        vt[1] = '{0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   1, 64'h100, 1, 0};
        vt[2] = '{0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   0, 64'h100, 1, 0};
        vt[3] = '{1, 64'h100, 0, 64'h0,   1, 64'h0,   1, 1, 64'h104, 0, 64'h100, 2, 1};
        vt[4] = '{1, 64'h300, 1, 64'h500, 0, 64'h0,   1, 0, 64'h104, 1, 64'h100, 2, 1};
        vt[5] = '{0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 0, 64'h104, 0, 64'h100, 2, 1};
        vt[6] = '{1, 64'h600, 1, 64'h400, 1, 64'h200, 1, 1, 64'h400, 0, 64'h100, 3, 2};
        vt[7] = '{0, 64'h0,   0, 64'h0,   0, 64'h0,   1, 0, 64'h400, 1, 64'h600, 3, 2};
        vt[8] = '{0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 0, 64'h400, 0, 64'h600, 3, 2};

        model_reset();
        reset = 1'b1;
        drive(0, '0, 0, '0, 0, '0, 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_outputs", {ex_stall, flush, redirect_valid, branch_resolved, actual_taken}, 5'b0);
        chk("rst_counts", {br_count, mp_count}, 64'h0);

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].v, vt[i].pc, vt[i].t, vt[i].tgt, vt[i].pt, vt[i].ptg, 0);
            step();
            chk($sformatf("tbl%0d_flush", i), flush, vt[i].e_flush);
            chk($sformatf("tbl%0d_rv", i), redirect_valid, vt[i].e_rv);
            chk($sformatf("tbl%0d_rpc", i), redirect_pc, vt[i].e_rpc);
            chk($sformatf("tbl%0d_br", i), branch_resolved, vt[i].e_br);
            chk($sformatf("tbl%0d_bpc", i), branch_pc, vt[i].e_bpc);
            chk($sformatf("tbl%0d_brc", i), br_count, vt[i].e_brc);
            chk($sformatf("tbl%0d_mpc", i), mp_count, vt[i].e_mpc);
        end

        // Queue fill under upd_hold: fifth branch dropped, then in-order drain.
        reset = 1'b1;
        drive(0, '0, 0, '0, 0, '0, 0);
        step();
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 64'(i * 16), 0, 64'h0, 0, 64'h0, 1);
            step();
            if (i == 4) chk("stall_after_4", ex_stall, 1'b1);
        end
        chk("stall_full", ex_stall, 1'b1);
        chk("br_count_5", br_count, 32'd5);
        for (int i = 1; i <= 4; i++) begin
            drive(0, '0, 0, '0, 0, '0, 0);
            step();
            chk("drain_strobe", branch_resolved, 1'b1);
            chk("drain_pc", branch_pc, 64'(i * 16));
            if (i == 1) chk("stall_after_pop", ex_stall, 1'b0);
        end
        step();
        chk("drain_done", branch_resolved, 1'b0);

        // Nine spaced mispredicts saturate the 3-bit counter, then reset mid-flush.
        for (int i = 0; i < 9; i++) begin
            drive(1, 64'h1000 + 64'(i * 8), 1, 64'h2000, 0, 64'h0, 0);
            step();
            drive(0, '0, 0, '0, 0, '0, 0);
            step();
            step();
        end
        chk("s_mp_sat", s_mp_count, 3'd7);
        chk("mp_9", mp_count, 32'd9);
        drive(1, 64'h3000, 1, 64'h4000, 0, 64'h0, 1);
        step();
        chk("flush_before_rst", flush, 1'b1);
        reset = 1'b1;
        drive(0, '0, 0, '0, 0, '0, 0);
        step();
        chk("rst_mid_flush", flush, 1'b0);
        chk("rst_mid_counts", {br_count, mp_count}, 64'h0);
        chk("rst_mid_s_mp", s_mp_count, 3'd0);
        reset = 1'b0;
        step();
        chk("rst_queue_empty", branch_resolved, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic [63:0] pc, tgt, ptg;
            bit t, pt;
            reset = ($urandom_range(0, 99) == 0);
            pc  = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            tgt = {$urandom, $urandom};
            t   = 1'($urandom_range(0, 1));
            pt  = ($urandom_range(0, 3) == 0) ? ~t : t;
            ptg = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : tgt;
            drive($urandom_range(0, 9) < 7, pc, t, tgt, pt, ptg, 1'($urandom_range(0, 1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bpu_update_ctrl.md
Name: bpu_update_ctrl

Overview:
Sits between the EX stage and BranchPredictionUnit. It compares each resolved branch against the prediction carried down the pipe, and raises flush plus redirect on a mispredict. It queues resolved branches and serialises them onto the BPU's single update port (branch_resolved / actual_taken / branch_pc / branch_target_resolved), one per cycle. It also keeps branch and mispredict statistics counters.

Parameters:
DEPTH, 4, update-queue entries (power of 2, >=2)
FLUSH_CYCLES, 2, cycles flush stays high per mispredict (>=1)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  resolved branch present in EX this cycle
ex_pc  in  64  PC of resolved branch
ex_taken  in  1  actual direction
ex_target  in  64  actual taken target
ex_pred_taken  in  1  direction predicted at fetch
ex_pred_target  in  64  target predicted at fetch
upd_hold  in  1  block BPU update this cycle (fetch-side port conflict)
ex_stall  out  1  queue full; EX must hold its branch
flush  out  1  squash younger instructions
redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  64  correct next PC
branch_resolved  out  1  BPU update strobe
actual_taken  out  1  BPU update direction
branch_pc  out  64  BPU update PC
branch_target_resolved  out  64  BPU update target
br_count  out  CNT_W  accepted branches, saturating
mp_count  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset: all outputs 0; queue empty; FSM in IDLE; counters 0. Applies on any cycle, including mid-flush or with a non-empty queue. Queue contents are discarded.
- accepted = ex_valid & (state==IDLE). In FLUSH, ex_valid is ignored entirely: no enqueue, no counting, no mispredict check.
- mispredict = accepted & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- Correct PC: ex_taken ? ex_target : ex_pc+4 (64-bit wrap).
- FSM:
  - IDLE -> FLUSH at an edge where mispredict=1.
  - FLUSH holds for FLUSH_CYCLES cycles (down-counter), then returns to IDLE.
  - flush=1 exactly while in FLUSH.
  - redirect_valid=1 only in the first FLUSH cycle. redirect_pc is registered at that edge and holds its value until the next mispredict.
- Mispredict latency: branch in EX at cycle N -> flush and redirect_valid high in cycle N+1.
- Queue: FIFO of {pc, taken, target}, DEPTH entries, wrap-around pointers, count 0..DEPTH.
  - ex_stall = (count==DEPTH), combinational.
  - Enqueue when accepted & !ex_stall. The mispredicting branch itself is enqueued.
  - If accepted while full, the entry is dropped. Mispredict detection and counting still occur.
- Drain, at each edge:
  - If !upd_hold & count>0 (pre-edge): pop head into the registered BPU outputs and set branch_resolved=1.
  - Otherwise branch_resolved=0; payload outputs hold their last values.
  - Enqueue at edge N is popped at edge N+1 earliest, so the strobe is high during cycle N+1..N+2.
  - Push and pop at the same edge: count unchanged. Pop is never from an entry written at the same edge.
  - Strobe is at most one cycle per entry, in strict FIFO order.
- Counters:
  - br_count += 1 per accepted.
  - mp_count += 1 per mispredict.
  - Both saturate at 2^CNT_W-1 (no wrap).
- Flush does not clear the queue. Updates from older, already-resolved branches remain valid.

Test Plan:
1. Reset held 2 cycles, then released with no activity -> every output 0, ex_stall=0, counters 0.
2. Correctly predicted branch, single cycle: ex_pc=0x100, ex_taken=1, ex_target=0x200, pred_taken=1, pred_target=0x200. Required response: flush stays 0; one cycle later branch_resolved=1 with branch_pc=0x100, actual_taken=1, branch_target_resolved=0x200 for exactly 1 cycle; br_count=1, mp_count=0.
3. Direction mispredict at cycle N: ex_pc=0x100, ex_taken=0, pred_taken=1. Required response: in cycle N+1, redirect_valid pulses with redirect_pc=0x104, and flush is high in cycles N+1 and N+2. An ex_valid at pc=0x300 during flush produces no update and no count change. mp_count=1, and the 0x100 update still reaches the BPU.
4. Target mispredict: ex_taken=1, pred_taken=1, ex_target=0x400, pred_target=0x200 -> redirect_pc=0x400, mp_count increments.
5. upd_hold=1 while 5 branches are presented on consecutive cycles (pc 0x10..0x50 step 0x10). Required response: ex_stall rises after the 4th; the 5th (0x50) is dropped. Then drop upd_hold: strobes appear on 4 consecutive cycles in order 0x10, 0x20, 0x30, 0x40. ex_stall falls after the first pop. br_count=5.
6. CNT_W=3 override, 9 mispredicts spaced by flush -> mp_count saturates at 7. Then assert reset during a FLUSH cycle -> next cycle flush=0, queue empty, counters 0.
